// File: rtl/wb_interconnect.sv
// -----------------------------------------------------------------------------
// wb_interconnect
// Single-master to NUM_SLAVES-slave pipelined Wishbone B4 interconnect.
// Only one transaction is in flight at a time. The word address is decoded
// against per-slave base/mask pairs, and the cycle is routed to the lowest
// matching slave. The master gets back ack plus read data, or an error. An
// error is returned for an unmapped address, for a slave error, or when the
// selected slave stays silent for TIMEOUT_CYCLES cycles.
//
// Handshake: the master request is accepted on a clock edge where
// m_cyc_i & m_stb_i are high and the block is idle (m_stall_o low). The
// slave takes the strobe on an edge where s_stb_o[idx] is high and
// s_stall_i[idx] is low. The response is a single-cycle s_ack_i/s_err_i
// from the selected slave. It is returned to the master one cycle later as
// a single-cycle m_ack_o/m_err_o.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i       master cycle, strobe, write enable
//   m_adr_i/m_dat_i/m_sel_i      master word address, write data, byte selects
//   m_stall_o/m_ack_o/m_err_o    master stall, ack, error
//   m_dat_o                      master read data
//   s_cyc_o/s_stb_o              per-slave cycle and strobe
//   s_we_o/s_adr_o/s_dat_o/s_sel_o  broadcast request fields
//   s_stall_i/s_ack_i/s_err_i    per-slave stall, ack, error
//   s_dat_i                      per-slave read data, slave i at [i*WB_DW +: WB_DW]
// -----------------------------------------------------------------------------
module wb_interconnect #(
  parameter int NUM_SLAVES     = 5,
  parameter int WB_AW          = 30,
  parameter int WB_DW          = 32,
  // {WBUART, LED, MTIMER, DDR3, DMEM} word base addresses
  parameter logic [NUM_SLAVES*WB_AW-1:0] START_ADDRESSES = {
    30'h2800_0008, 30'h2800_0004, 30'h2800_0000, 30'h1000_0000, 30'h2400_0000},
  parameter logic [NUM_SLAVES*WB_AW-1:0] MASKS = {
    30'h3FFF_FFFC, 30'h3FFF_FFFC, 30'h3FFF_FFFC, 30'h3000_0000, 30'h3F00_0000},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        m_cyc_i,
  input  logic                        m_stb_i,
  input  logic                        m_we_i,
  input  logic [WB_AW-1:0]            m_adr_i,
  input  logic [WB_DW-1:0]            m_dat_i,
  input  logic [WB_DW/8-1:0]          m_sel_i,
  output logic                        m_stall_o,
  output logic                        m_ack_o,
  output logic                        m_err_o,
  output logic [WB_DW-1:0]            m_dat_o,
  output logic [NUM_SLAVES-1:0]       s_cyc_o,
  output logic [NUM_SLAVES-1:0]       s_stb_o,
  output logic                        s_we_o,
  output logic [WB_AW-1:0]            s_adr_o,
  output logic [WB_DW-1:0]            s_dat_o,
  output logic [WB_DW/8-1:0]          s_sel_o,
  input  logic [NUM_SLAVES-1:0]       s_stall_i,
  input  logic [NUM_SLAVES-1:0]       s_ack_i,
  input  logic [NUM_SLAVES-1:0]       s_err_i,
  input  logic [NUM_SLAVES*WB_DW-1:0] s_dat_i
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [IW-1:0]        r_idx;
  logic                 r_we;
  logic [WB_AW-1:0]     r_adr;
  logic [WB_DW-1:0]     r_wdat;
  logic [WB_DW/8-1:0]   r_sel;
  logic                 r_ack;
  logic                 r_err;
  logic [WB_DW-1:0]     r_rdat;

  logic                 w_hit;
  logic [IW-1:0]        w_hit_idx;
  logic                 w_load;
  logic                 w_ack_nxt;
  logic                 w_err_nxt;
  logic [WB_DW-1:0]     w_rdat_nxt;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic                 w_sel_ack;
  logic                 w_sel_err;
  logic                 w_sel_stall;
  logic                 w_resp_ok;

  // Address decode. Scanning from the top index downward lets the lowest
  // matching index overwrite any higher match.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_adr_i & MASKS[i*WB_AW +: WB_AW]) ==
          (START_ADDRESSES[i*WB_AW +: WB_AW] & MASKS[i*WB_AW +: WB_AW])) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
    end
  end

  assign w_onehot    = {{(NUM_SLAVES-1){1'b0}}, 1'b1} << r_idx;
  assign w_sel_ack   = s_ack_i[r_idx];
  assign w_sel_err   = s_err_i[r_idx];
  assign w_sel_stall = s_stall_i[r_idx];
  // A response counts in WAIT, or in ISSUE when the strobe is taken on the
  // same edge (the slave answered without a separate stall-free cycle).
  assign w_resp_ok   = (r_state == WAIT) || ((r_state == ISSUE) && !w_sel_stall);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_rdat_nxt  = '0;
    case (r_state)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = w_hit ? ISSUE : ERR;
        end
      end
      ISSUE, WAIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // Priority: master abort, slave error, slave ack, timeout, stall.
        if (!m_cyc_i) begin
          w_state_nxt = IDLE;
        end else if (w_resp_ok && w_sel_err) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_resp_ok && w_sel_ack) begin
          w_ack_nxt   = 1'b1;
          w_rdat_nxt  = r_we ? '0 : s_dat_i[r_idx*WB_DW +: WB_DW];
          w_state_nxt = IDLE;
        end else if (r_cnt == TO_MAX) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else if ((r_state == ISSUE) && !w_sel_stall) begin
          w_state_nxt = WAIT;
        end
      end
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_wdat  <= '0;
      r_sel   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_rdat  <= w_rdat_nxt;
      if (w_load) begin
        r_idx  <= w_hit_idx;
        r_we   <= m_we_i;
        r_adr  <= m_adr_i;
        r_wdat <= m_dat_i;
        r_sel  <= m_sel_i;
      end
    end
  end

  assign m_stall_o = (r_state != IDLE);
  assign m_ack_o   = r_ack;
  // The unmapped-address error is the one-cycle ERR state itself.
  assign m_err_o   = r_err || (r_state == ERR);
  assign m_dat_o   = r_rdat;
  assign s_cyc_o   = ((r_state == ISSUE) || (r_state == WAIT)) ? w_onehot : '0;
  assign s_stb_o   = (r_state == ISSUE) ? w_onehot : '0;
  assign s_we_o    = r_we;
  assign s_adr_o   = r_adr;
  assign s_dat_o   = r_wdat;
  assign s_sel_o   = r_sel;

endmodule

// File: doc/wb_interconnect.md
Name: wb_interconnect

Overview:
- Single-master to NUM_SLAVES-slave pipelined Wishbone B4 interconnect, one outstanding transaction at a time.
- Sits between the core's data bus port and the platform slaves (DMEM, DDR3, MTIMER, LED driver, WBUART).
- Decodes the word address against per-slave base/mask pairs and routes the cycle to the matching slave.
- Returns ack/data to the master, or an error for unmapped addresses and for slaves that never respond.

Parameters:
- NUM_SLAVES, 5, number of slave ports.
- WB_AW, 30, word address width.
- WB_DW, 32, data width.
- START_ADDRESSES, platform map, flattened {slaveN-1..slave0} word base addresses, WB_AW bits each.
- MASKS, platform map, flattened word address masks, same packing as START_ADDRESSES.
- TIMEOUT_CYCLES, 255, cycles without slave ack/err before the interconnect aborts with error.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- m_cyc_i  in  1  master cycle
- m_stb_i  in  1  master strobe
- m_we_i  in  1  master write enable
- m_adr_i  in  WB_AW  master word address
- m_dat_i  in  WB_DW  master write data
- m_sel_i  in  WB_DW/8  master byte selects
- m_stall_o  out  1  master stall
- m_ack_o  out  1  master ack
- m_err_o  out  1  master error
- m_dat_o  out  WB_DW  master read data
- s_cyc_o  out  NUM_SLAVES  per-slave cycle
- s_stb_o  out  NUM_SLAVES  per-slave strobe
- s_we_o  out  1  broadcast write enable
- s_adr_o  out  WB_AW  broadcast address
- s_dat_o  out  WB_DW  broadcast write data
- s_sel_o  out  WB_DW/8  broadcast byte selects
- s_stall_i  in  NUM_SLAVES  per-slave stall
- s_ack_i  in  NUM_SLAVES  per-slave ack
- s_err_i  in  NUM_SLAVES  per-slave error
- s_dat_i  in  NUM_SLAVES*WB_DW  per-slave read data, slave i at bits [i*WB_DW +: WB_DW]

Behaviour:
- One clock domain (clk_i); reset is synchronous, active-high (rst_i).
- Reset: state IDLE, timeout counter 0, all outputs 0 (including m_stall_o, s_adr_o/s_dat_o/s_sel_o/s_we_o). Reset mid-transaction drops slave cyc/stb in the next cycle; no ack or err is emitted.
- Decode (combinational, on m_adr_i): slave i hits when (m_adr_i & MASK_i) == (START_i & MASK_i). If several slaves hit, the lowest index wins.
- IDLE:
  - m_stall_o=0.
  - On m_cyc_i & m_stb_i, register adr/we/dat/sel and the hit index. Go to ISSUE on a hit, otherwise to ERR.
- ISSUE:
  - m_stall_o=1; s_cyc_o[idx]=1, s_stb_o[idx]=1.
  - When !s_stall_i[idx], drop stb in the next cycle and go to WAIT.
  - An ack/err that arrives while still in ISSUE (stall low in the same cycle) is honoured as in WAIT.
- WAIT:
  - m_stall_o=1; s_cyc_o[idx]=1, stb=0.
  - On s_ack_i[idx]: next cycle m_ack_o=1 for exactly 1 cycle, m_dat_o = registered s_dat_i slice of idx (writes return 0); slave cyc drops; go to IDLE.
  - On s_err_i[idx]: same timing, but m_err_o=1 instead of m_ack_o.
  - ack and err in the same cycle: err wins.
- ERR (unmapped address): m_err_o=1 for exactly 1 cycle, no slave is ever strobed, then IDLE.
- Timeout:
  - Counter of width $clog2(TIMEOUT_CYCLES+1) clears on accept and increments each cycle in ISSUE/WAIT.
  - At TIMEOUT_CYCLES: drop slave cyc/stb, m_err_o=1 for 1 cycle, go to IDLE.
  - A slave ack/err arriving on that same cycle takes precedence over the timeout.
- Abort: m_cyc_i low in ISSUE/WAIT drops slave cyc/stb the next cycle and returns to IDLE with no ack/err. A late slave ack after the abort is ignored.
- ack/err/stall from non-selected slaves are always ignored.
- m_ack_o and m_err_o are never both high. Each accepted request produces exactly one ack or err unless it is aborted.
- Latency: a read to a zero-wait slave (no stall, ack the cycle after stb) gives m_ack_o 3 cycles after the master accept edge.
- m_stall_o=1 is held from the cycle after accept until the cycle m_ack_o/m_err_o is asserted. New requests are accepted only in IDLE, so back-to-back requests pay 1 idle cycle.

Test Plan:
- Read, addr 0x2400_0010 (byte 0x9000_0040, DMEM) -> s_cyc_o=5'b00001, s_adr_o=0x2400_0010; slave returns 0xDEADBEEF with ack -> m_ack_o pulse 3 cycles after accept, m_dat_o=0xDEADBEEF.
- Write to LED, addr 0x2800_0004, dat 0x0000_00A5, sel 4'hF, slave stalls 2 cycles -> s_stb_o[3] held 3 cycles; exactly one m_ack_o; no other s_cyc_o bit asserted.
- Unmapped addr 0x0000_0400 -> all s_cyc_o stay 0; m_err_o pulses 1 cycle one cycle after accept.
- Slave 2 (MTIMER, addr 0x2800_0000) never acks, TIMEOUT_CYCLES=255 -> m_err_o at counter 255; s_cyc_o[2] low afterwards; a late ack is ignored.
- Slave asserts ack and err together -> only m_err_o=1; m_cyc_i dropped mid-WAIT -> no ack/err, back to IDLE, next request accepted.
- rst_i asserted during WAIT -> all outputs 0 the next cycle; no spurious ack after reset release.
